ball_tracker: RTL

- Sits directly downstream of ball detection and consumes its filtered RGB pixel stream, using the same VGA H/V counters.
- Each pixel is classified as ball or not ball by a green-dominance colour test.
- Per frame, the block accumulates pixel count, coordinate sums and bounding box.
- At end of frame, a serial divider computes the ball centroid and the block publishes a stable position record for the paddle/game logic.

---
 rtl/ball_tracker_pkg.sv | 39 +++
 rtl/ball_tracker_divider.sv | 70 +++++++
 rtl/ball_tracker.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ball_tracker_pkg.sv
// Shared widths, FSM states, snapshot record and colour classifier for ball_tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ball_tracker_pkg;

  localparam int CNT_W = 19;
  localparam int SX_W  = 29;
  localparam int SY_W  = 28;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int CRD_W = 13;

  typedef enum logic [1:0] {
    ACCUM,
    DIVIDE,
    PUBLISH
  } state_t;

  // Frame-end shadow of the live pixel count and bounding box. The coordinate
  // sums are latched by the two dividers on the same edge, so they are not
  // duplicated here.
  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [X_W-1:0]   x0;
    logic [X_W-1:0]   x1;
    logic [Y_W-1:0]   y0;
    logic [Y_W-1:0]   y1;
  } snap_t;

  // Green-dominance test, evaluated at 9 bits so channel+margin cannot wrap.
  function automatic logic is_ball_colour(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b, input logic [8:0] g_min,
                                          input logic [8:0] margin);
    return ({1'b0, g} >= g_min) &&
           ({1'b0, g} >= ({1'b0, r} + margin)) &&
           ({1'b0, g} >= ({1'b0, b} + margin));
  endfunction

endpackage

// File: rtl/ball_tracker_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, start/done handshake.
// Latency: o_done pulses DIVIDEND_W cycles after the edge that samples i_start.
// Backpressure: none; a new i_start restarts the operation, quotient holds until then.
module serial_divider #(
  parameter int DIVIDEND_W = 29,
  parameter int DIVISOR_W  = 19,
  parameter int QUOT_W     = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DIVIDEND_W-1:0] i_dividend,
  input  logic [DIVISOR_W-1:0]  i_divisor,
  output logic                  o_done,
  output logic [QUOT_W-1:0]     o_quotient
);

  localparam int STEP_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  r_rem;
  logic [DIVIDEND_W-1:0] r_quo;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [STEP_W-1:0]     r_step;
  logic                  r_busy;
  logic                  r_done;

  logic [DIVISOR_W:0]    w_shift;
  logic                  w_fits;
  logic [DIVISOR_W-1:0]  w_diff;

  // The partial remainder is always below the divisor, so when the trial
  // subtraction fits the difference is exact in DIVISOR_W bits.
  assign w_shift = {r_rem, r_quo[DIVIDEND_W-1]};
  assign w_fits  = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[DIVISOR_W-1:0] - r_dvs;

  assign o_done     = r_done;
  assign o_quotient = r_quo[QUOT_W-1:0];

  // Load operands on start, then shift one quotient bit in per cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_step <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= '0;
        r_quo  <= i_dividend;
        r_dvs  <= i_divisor;
        r_step <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_fits ? w_diff : w_shift[DIVISOR_W-1:0];
        r_quo <= {r_quo[DIVIDEND_W-2:0], w_fits};
        if (r_step == STEP_W'(DIVIDEND_W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_step <= r_step + STEP_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ball_tracker.sv
// Per-frame green-ball centroid, bounding box and pixel count from the VGA pixel stream.
// Latency: outputs + o_frame_done 31 cycles after the frame-end cycle (2 when no ball pixels).
// Backpressure: none; streaming input, results held until the next publish.
module ball_tracker
  import ball_tracker_pkg::*;
#(
  parameter int X_START    = 144,
  parameter int Y_START    = 33,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int G_MIN      = 100,
  parameter int MARGIN     = 40,
  parameter int MIN_PIXELS = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [7:0]       i_r_in,
  input  logic [7:0]       i_g_in,
  input  logic [7:0]       i_b_in,
  input  logic [CRD_W-1:0] i_vga_h_cnt,
  input  logic [CRD_W-1:0] i_vga_v_cnt,
  output logic [X_W-1:0]   o_ball_x,
  output logic [Y_W-1:0]   o_ball_y,
  output logic [X_W-1:0]   o_box_x0,
  output logic [X_W-1:0]   o_box_x1,
  output logic [Y_W-1:0]   o_box_y0,
  output logic [Y_W-1:0]   o_box_y1,
  output logic [CNT_W-1:0] o_pix_count,
  output logic             o_ball_valid,
  output logic             o_frame_done
);

  localparam logic [CRD_W-1:0] H_LO = CRD_W'(X_START);
  localparam logic [CRD_W-1:0] H_HI = CRD_W'(X_START + WIDTH);
  localparam logic [CRD_W-1:0] V_LO = CRD_W'(Y_START);
  localparam logic [CRD_W-1:0] V_HI = CRD_W'(Y_START + HEIGHT);

  logic [CNT_W-1:0] r_cnt;
  logic [SX_W-1:0]  r_sum_x;
  logic [SY_W-1:0]  r_sum_y;
  logic [X_W-1:0]   r_x_min, r_x_max;
  logic [Y_W-1:0]   r_y_min, r_y_max;
  logic [CRD_W-1:0] r_v_prev;
  state_t           r_state;
  snap_t            r_snap;

  logic             w_in_win, w_ball, w_frame_end, w_take_snap, w_start, w_snap_valid;
  logic [X_W-1:0]   w_x, w_quo_x;
  logic [Y_W-1:0]   w_y, w_quo_y;
  logic             w_done_x, w_done_y;

  assign w_in_win = (i_vga_h_cnt >= H_LO) && (i_vga_h_cnt < H_HI) &&
                    (i_vga_v_cnt >= V_LO) && (i_vga_v_cnt < V_HI);
  // Offsets are below WIDTH/HEIGHT inside the window, so low-bit subtraction is exact.
  assign w_x = i_vga_h_cnt[X_W-1:0] - H_LO[X_W-1:0];
  assign w_y = i_vga_v_cnt[Y_W-1:0] - V_LO[Y_W-1:0];
  assign w_ball = w_in_win && i_enable &&
                  is_ball_colour(i_r_in, i_g_in, i_b_in, 9'(G_MIN), 9'(MARGIN));

  assign w_frame_end  = (i_vga_v_cnt >= V_HI) && (r_v_prev < V_HI);
  assign w_take_snap  = (r_state == ACCUM) && w_frame_end;
  assign w_start      = w_take_snap && (r_cnt != '0);
  assign w_snap_valid = (r_snap.cnt >= CNT_W'(MIN_PIXELS));

  // Previous V count for first-line-of-blanking detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_v_prev <= '0;
    else          r_v_prev <= i_vga_v_cnt;
  end

  // Live per-frame accumulators; cleared on the edge that snapshots them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_x_min <= '0;
      r_x_max <= '0;
      r_y_min <= '0;
      r_y_max <= '0;
    end else if (w_take_snap) begin
      r_cnt   <= '0;
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_x_min <= '0;
      r_x_max <= '0;
      r_y_min <= '0;
      r_y_max <= '0;
    end else if (w_ball) begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_sum_x <= r_sum_x + {{(SX_W-X_W){1'b0}}, w_x};
      r_sum_y <= r_sum_y + {{(SY_W-Y_W){1'b0}}, w_y};
      if (r_cnt == '0) begin
        r_x_min <= w_x;
        r_x_max <= w_x;
        r_y_min <= w_y;
        r_y_max <= w_y;
      end else begin
        if (w_x < r_x_min) r_x_min <= w_x;
        if (w_x > r_x_max) r_x_max <= w_x;
        if (w_y < r_y_min) r_y_min <= w_y;
        if (w_y > r_y_max) r_y_max <= w_y;
      end
    end
  end

  // Both dividers run the full dividend width so they finish together.
  serial_divider #(.DIVIDEND_W(SX_W), .DIVISOR_W(CNT_W), .QUOT_W(X_W)) u_div_x (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (w_start),
    .i_dividend (r_sum_x),
    .i_divisor  (r_cnt),
    .o_done     (w_done_x),
    .o_quotient (w_quo_x)
  );

  serial_divider #(.DIVIDEND_W(SX_W), .DIVISOR_W(CNT_W), .QUOT_W(Y_W)) u_div_y (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (w_start),
    .i_dividend ({{(SX_W-SY_W){1'b0}}, r_sum_y}),
    .i_divisor  (r_cnt),
    .o_done     (w_done_y),
    .o_quotient (w_quo_y)
  );

  // Frame sequencing: snapshot at frame end, wait for the centroid, publish once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ACCUM;
      r_snap       <= '0;
      o_ball_x     <= '0;
      o_ball_y     <= '0;
      o_box_x0     <= '0;
      o_box_x1     <= '0;
      o_box_y0     <= '0;
      o_box_y1     <= '0;
      o_pix_count  <= '0;
      o_ball_valid <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (r_state)
        ACCUM: begin
          if (w_frame_end) begin
            r_snap.cnt <= r_cnt;
            r_snap.x0  <= r_x_min;
            r_snap.x1  <= r_x_max;
            r_snap.y0  <= r_y_min;
            r_snap.y1  <= r_y_max;
            r_state    <= DIVIDE;
          end
        end
        DIVIDE: begin
          // An empty frame never started the dividers; skip straight on.
          if ((r_snap.cnt == '0) || (w_done_x && w_done_y)) r_state <= PUBLISH;
        end
        PUBLISH: begin
          o_pix_count  <= r_snap.cnt;
          o_ball_valid <= w_snap_valid;
          if (w_snap_valid) begin
            o_ball_x <= w_quo_x;
            o_ball_y <= w_quo_y;
            o_box_x0 <= r_snap.x0;
            o_box_x1 <= r_snap.x1;
            o_box_y0 <= r_snap.y0;
            o_box_y1 <= r_snap.y1;
          end
          o_frame_done <= 1'b1;
          r_state      <= ACCUM;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule
